fetch_stage: RTL
================

Name: fetch_stage

Overview:
- Instruction-fetch stage of the pipelined RV32I core. Sits directly upstream of the instruction memory.
- Owns the program counter and drives it as the memory address.
- Takes the combinational instruction word back from memory and registers it, with PC and PC+4, into the IF/ID pipeline register for decode.
- Handles hazard-unit stall/flush, execute-stage redirects, and a halt state for bench termination.

Parameters:
- ADDRESS_WIDTH, 32, PC / memory address width.
- DATA_WIDTH, 32, instruction word width.
- RESET_PC, 32'h00000000, PC value after reset. Memory-relative; the memory applies its own base offset.
- NOP_INSTR, 32'h00000013, bubble encoding (addi x0,x0,0) loaded into IF/ID on flush/reset.
- HALT_INSTR, 32'h0000006F, self-loop (jal x0,0) that triggers the halt state.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall_f  in  1  hold PC and IF/ID contents.
- flush_d  in  1  replace IF/ID contents with a bubble.
- pc_src_e  in  1  redirect request from execute (taken branch/jump).
- pc_target_e  in  ADDRESS_WIDTH  redirect target.
- instr_f  in  DATA_WIDTH  instruction word returned combinationally by instruction memory for pc_f.
- pc_f  out  ADDRESS_WIDTH  current PC, drives memory address.
- instr_d  out  DATA_WIDTH  registered instruction to decode.
- pc_d  out  ADDRESS_WIDTH  registered PC of instr_d.
- pc_plus4_d  out  ADDRESS_WIDTH  registered pc_d+4.
- valid_d  out  1  instr_d is a real instruction, not a bubble.
- misalign_err  out  1  sticky: a redirect target had bits[1:0] != 0.
- halted  out  1  high in HALTED state.

Behaviour:
- Reset, asynchronous, immediate:
  - pc_f=RESET_PC, instr_d=NOP_INSTR, pc_d=0, pc_plus4_d=0.
  - valid_d=0, misalign_err=0, halted=0, state=BOOT.
- Reset deasserted mid-program: the next edge behaves as the first post-reset edge.
- States:
  - BOOT: one cycle. IF/ID is loaded with the fetch at RESET_PC, PC advances, then the FSM goes to RUN. Guarantees one clean bubble after reset.
  - RUN: normal fetch.
  - HALTED: entered when a fetch of HALT_INSTR is captured into IF/ID (valid, not flushed, not stalled). In HALTED:
    - PC frozen and IF/ID frozen (halt instruction stays in decode, valid_d=1).
    - halted=1; stall_f and flush_d are ignored.
    - The only exits are a pc_src_e redirect (goes to RUN at pc_target_e) or rst.
- PC next-value priority, highest first:
  1. pc_src_e=1: pc_f <= {pc_target_e[ADDRESS_WIDTH-1:2],2'b00}. If pc_target_e[1:0]!=0, misalign_err <= 1 (sticky until reset). A redirect overrides stall_f.
  2. stall_f=1: pc_f holds.
  3. Otherwise pc_f <= pc_f+4. Arithmetic is modulo 2^ADDRESS_WIDTH; 32'hFFFFFFFC+4 wraps to 0 with no flag.
- IF/ID priority, highest first:
  1. flush_d=1: instr_d=NOP_INSTR, valid_d=0, pc_d/pc_plus4_d=0. Flush beats stall.
  2. stall_f=1: all IF/ID fields hold.
  3. Otherwise: instr_d<=instr_f, pc_d<=pc_f, pc_plus4_d<=pc_f+4, valid_d<=1.
- Redirect without flush: IF/ID still captures the wrong-path instruction. The hazard unit must assert flush_d together with pc_src_e; the block does not infer it.
- Latency:
  - pc_f drives memory in the same cycle.
  - The instruction appears on instr_d one edge later.
  - Redirect target appears on pc_f one edge after pc_src_e; its instruction reaches instr_d on the following edge.
- No combinational path from any input to pc_f. pc_f is a pure register output.

Test Plan:
- Reset then free-run, memory returns addr-dependent words (e.g. addr+32'h100):
  - pc_f sequence is 0,4,8,C.
  - instr_d follows one cycle behind; valid_d=0 during BOOT, then 1.
- stall_f high 2 cycles at pc_f=8:
  - pc_f stays 8 and instr_d/pc_d hold for 2 cycles.
  - Resumes with 8 then C; no instruction is skipped or duplicated.
- pc_src_e=1, pc_target_e=32'h40, flush_d=1 with stall_f=1 simultaneously:
  - Next cycle pc_f=32'h40, instr_d=32'h00000013, valid_d=0.
  - Following cycle pc_d=32'h40.
- Redirect to 32'h42:
  - pc_f=32'h40, misalign_err=1.
  - misalign_err stays 1 across further redirects until rst.
- Memory returns 32'h0000006F at pc=32'h10:
  - halted=1, pc_f frozen, instr_d=32'h6F, valid_d=1; stall_f/flush_d have no effect.
  - A later pc_src_e to 32'h0 returns to RUN, halted=0.
- Assert rst asynchronously mid-cycle while at pc_f=32'h24:
  - Outputs reset immediately, without waiting for an edge.
  - After release, a BOOT bubble, then fetch restarts at 0. pc_f=32'hFFFFFFFC free-runs to 0.

Source files
------------

// File: rtl/fetch_stage.sv
// Purpose : RV32I instruction-fetch stage; owns the PC, drives it to instruction memory
//           and registers {instr, pc, pc+4, valid} into the IF/ID pipeline register.
// Latency : pc_f is a pure register output; the fetched word reaches instr_d one edge later.
// Backpr. : stall_f holds PC and IF/ID; flush_d bubbles IF/ID; pc_src_e redirects the PC.
//
// Ports:
//   clk, rst           clock, asynchronous active-high reset
//   stall_f, flush_d   hazard-unit hold / bubble controls
//   pc_src_e,          execute-stage redirect request and target
//   pc_target_e
//   instr_f            combinational instruction word for pc_f
//   pc_f               fetch address
//   instr_d, pc_d,     IF/ID register contents
//   pc_plus4_d,
//   valid_d
//   misalign_err       sticky flag: some redirect target was not word aligned
//   halted             high while parked on the halt self-loop
module fetch_stage #(
  parameter int                       ADDRESS_WIDTH = 32,
  parameter int                       DATA_WIDTH    = 32,
  parameter logic [ADDRESS_WIDTH-1:0] RESET_PC      = 32'h00000000,
  parameter logic [DATA_WIDTH-1:0]    NOP_INSTR     = 32'h00000013,
  parameter logic [DATA_WIDTH-1:0]    HALT_INSTR    = 32'h0000006F
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     stall_f,
  input  logic                     flush_d,
  input  logic                     pc_src_e,
  input  logic [ADDRESS_WIDTH-1:0] pc_target_e,
  input  logic [DATA_WIDTH-1:0]    instr_f,
  output logic [ADDRESS_WIDTH-1:0] pc_f,
  output logic [DATA_WIDTH-1:0]    instr_d,
  output logic [ADDRESS_WIDTH-1:0] pc_d,
  output logic [ADDRESS_WIDTH-1:0] pc_plus4_d,
  output logic                     valid_d,
  output logic                     misalign_err,
  output logic                     halted
);

  typedef enum logic [1:0] {
    BOOT   = 2'd0,
    RUN    = 2'd1,
    HALTED = 2'd2
  } state_t;

  state_t                   state_q, state_d;
  logic [ADDRESS_WIDTH-1:0] pc_q, pc_d_nx;
  logic [DATA_WIDTH-1:0]    ifid_instr_q, ifid_instr_d;
  logic [ADDRESS_WIDTH-1:0] ifid_pc_q, ifid_pc_d;
  logic [ADDRESS_WIDTH-1:0] ifid_pc4_q, ifid_pc4_d;
  logic                     ifid_vld_q, ifid_vld_d;
  logic                     misalign_q, misalign_d;
  logic                     halted_q, halted_d;

  logic [ADDRESS_WIDTH-1:0] pc_plus4;
  logic                     in_halt;
  logic                     capture;

  assign pc_plus4 = pc_q + ADDRESS_WIDTH'(4);
  assign in_halt  = (state_q == HALTED);

  always_comb begin
    state_d      = state_q;
    pc_d_nx      = pc_q;
    ifid_instr_d = ifid_instr_q;
    ifid_pc_d    = ifid_pc_q;
    ifid_pc4_d   = ifid_pc4_q;
    ifid_vld_d   = ifid_vld_q;
    misalign_d   = misalign_q;
    capture      = 1'b0;

    // PC: redirect is honoured in every state, including HALTED, and beats stall.
    if (pc_src_e) begin
      pc_d_nx    = {pc_target_e[ADDRESS_WIDTH-1:2], 2'b00};
      misalign_d = misalign_q | (pc_target_e[1:0] != 2'b00);
    end else if (!in_halt && !stall_f) begin
      pc_d_nx = pc_plus4;
    end

    // IF/ID: frozen while halted (stall/flush ignored); flush beats stall otherwise.
    if (!in_halt) begin
      if (flush_d) begin
        ifid_instr_d = NOP_INSTR;
        ifid_pc_d    = '0;
        ifid_pc4_d   = '0;
        ifid_vld_d   = 1'b0;
      end else if (!stall_f) begin
        ifid_instr_d = instr_f;
        ifid_pc_d    = pc_q;
        ifid_pc4_d   = pc_plus4;
        ifid_vld_d   = 1'b1;
        capture      = 1'b1;
      end
    end

    // A halt word captured on a wrong path (same-edge redirect) must not park the core.
    if (in_halt) begin
      if (pc_src_e) state_d = RUN;
    end else if (capture && (instr_f == HALT_INSTR) && !pc_src_e) begin
      state_d = HALTED;
    end else begin
      state_d = RUN;
    end

    halted_d = (state_d == HALTED);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= BOOT;
      pc_q         <= RESET_PC;
      ifid_instr_q <= NOP_INSTR;
      ifid_pc_q    <= '0;
      ifid_pc4_q   <= '0;
      ifid_vld_q   <= 1'b0;
      misalign_q   <= 1'b0;
      halted_q     <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d_nx;
      ifid_instr_q <= ifid_instr_d;
      ifid_pc_q    <= ifid_pc_d;
      ifid_pc4_q   <= ifid_pc4_d;
      ifid_vld_q   <= ifid_vld_d;
      misalign_q   <= misalign_d;
      halted_q     <= halted_d;
    end
  end

  assign pc_f         = pc_q;
  assign instr_d      = ifid_instr_q;
  assign pc_d         = ifid_pc_q;
  assign pc_plus4_d   = ifid_pc4_q;
  assign valid_d      = ifid_vld_q;
  assign misalign_err = misalign_q;
  assign halted       = halted_q;

endmodule
